// File: rtl/vip_matrix_generate_nxn.sv
// rtl/vip_matrix_generate_nxn.sv - KSIZE x KSIZE neighbourhood window generator from a raster pixel stream
module vip_matrix_generate_nxn #(
   parameter int DW     = 8,
   parameter int KSIZE  = 3,
   parameter int IMG_W  = 640,
   parameter int BORDER = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      per_frame_vsync,
   input  logic                      per_frame_href,
   input  logic                      per_frame_clken,
   input  logic [DW-1:0]             per_img_data,
   output logic                      matrix_frame_vsync,
   output logic                      matrix_frame_href,
   output logic                      matrix_frame_clken,
   output logic [KSIZE*KSIZE*DW-1:0] matrix_win,
   output logic                      matrix_win_valid,
   output logic                      line_ovf
);

   localparam int NL = KSIZE - 1;
   localparam int CW = $clog2(IMG_W + 1);
   localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = $clog2(KSIZE);
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_W);
   localparam logic [CW-1:0] COL_K   = CW'(KSIZE - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(KSIZE - 1);

   logic [DW-1:0] lb [NL][IMG_W];
   logic [DW-1:0] lb_rd [NL];
   logic [DW-1:0] win [KSIZE][KSIZE];
   logic [DW-1:0] raw [KSIZE];
   logic [DW-1:0] vec [KSIZE];

   logic          vsync_q, href_q;
   logic [CW-1:0] col_cnt, col_eff, col_d1;
   logic [RW-1:0] row_cnt, row_eff, row_d1, top;
   logic [2:0]    ctrl_d1, ctrl_d2;
   logic [DW-1:0] pix_d1;
   logic          first_d1;
   logic          accept, vs_rise, hs_rise, hs_fall, in_range;
   logic [AW-1:0] addr;

   always_comb begin
      accept   = per_frame_href & per_frame_clken;
      vs_rise  = per_frame_vsync & ~vsync_q;
      hs_rise  = per_frame_href & ~href_q;
      hs_fall  = ~per_frame_href & href_q;
      col_eff  = hs_rise ? '0 : col_cnt;
      row_eff  = vs_rise ? '0 : row_cnt;
      in_range = (col_eff < COL_MAX);
      addr     = col_eff[AW-1:0];
   end

   // Line buffers are never reset; row masking hides stale content.
   always_ff @(posedge clk) begin
      if (!rst && accept && in_range) begin
         lb[0][addr] <= per_img_data;
         for (int k = 1; k < NL; k++) lb[k][addr] <= lb[k-1][addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_q  <= 1'b0;
         href_q   <= 1'b0;
         col_cnt  <= '0;
         row_cnt  <= '0;
         line_ovf <= 1'b0;
         ctrl_d1  <= '0;
         pix_d1   <= '0;
         col_d1   <= '0;
         row_d1   <= '0;
         first_d1 <= 1'b0;
         for (int k = 0; k < NL; k++) lb_rd[k] <= '0;
      end else begin
         vsync_q <= per_frame_vsync;
         href_q  <= per_frame_href;
         ctrl_d1 <= {per_frame_vsync, per_frame_href, per_frame_clken};

         if (vs_rise) row_cnt <= '0;
         else if (hs_fall && row_cnt != ROW_MAX) row_cnt <= row_cnt + RW'(1);

         if (accept && in_range) col_cnt <= col_eff + CW'(1);
         else                    col_cnt <= col_eff;

         if (accept && !in_range) line_ovf <= 1'b1;
         else if (vs_rise)        line_ovf <= 1'b0;

         if (accept) begin
            pix_d1   <= per_img_data;
            col_d1   <= col_eff;
            row_d1   <= row_eff;
            first_d1 <= (col_eff == '0);
            for (int k = 0; k < NL; k++) lb_rd[k] <= in_range ? lb[k][addr] : '0;
         end
      end
   end

   // Column vector oldest row first; rows above frame line 0 are masked.
   always_comb begin
      top = ROW_MAX - row_d1;
      raw[NL] = pix_d1;
      for (int r = 0; r < NL; r++) raw[r] = lb_rd[NL-1-r];
      for (int r = 0; r < KSIZE; r++) begin
         if (RW'(r) < top) vec[r] = (BORDER == 1) ? raw[top] : '0;
         else              vec[r] = raw[r];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_d2          <= '0;
         matrix_win_valid <= 1'b0;
         for (int r = 0; r < KSIZE; r++)
            for (int c = 0; c < KSIZE; c++) win[r][c] <= '0;
      end else begin
         ctrl_d2 <= ctrl_d1;
         if (!ctrl_d1[1]) begin
            matrix_win_valid <= 1'b0;
            for (int r = 0; r < KSIZE; r++)
               for (int c = 0; c < KSIZE; c++) win[r][c] <= '0;
         end else if (ctrl_d1[0]) begin
            matrix_win_valid <= (row_d1 == ROW_MAX) && (col_d1 >= COL_K);
            for (int r = 0; r < KSIZE; r++) begin
               for (int c = 0; c < NL; c++) begin
                  if (first_d1) win[r][c] <= (BORDER == 1) ? vec[r] : '0;
                  else          win[r][c] <= win[r][c+1];
               end
               win[r][NL] <= vec[r];
            end
         end else begin
            matrix_win_valid <= 1'b0;
         end
      end
   end

   assign matrix_frame_vsync = ctrl_d2[2];
   assign matrix_frame_href  = ctrl_d2[1];
   assign matrix_frame_clken = ctrl_d2[0];

   for (genvar r = 0; r < KSIZE; r++) begin : g_row
      for (genvar c = 0; c < KSIZE; c++) begin : g_col
         assign matrix_win[((r*KSIZE)+c)*DW +: DW] = win[r][c];
      end
   end

endmodule

// File: tb/tb_vip_matrix_generate_nxn.sv
// tb/tb_vip_matrix_generate_nxn.sv - directed bench for vip_matrix_generate_nxn
module tb_vip_matrix_generate_nxn;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, vsync, href, clken;
   logic [7:0] data;

   logic v0, h0, c0, wv0, ovf0;
   logic v1, h1, c1, wv1, ovf1;
   logic v5, h5, c5, wv5, ovf5;
   logic [71:0]  w0, w1;
   logic [199:0] w5;

   vip_matrix_generate_nxn #(.DW(8), .KSIZE(3), .IMG_W(8), .BORDER(0)) u_dut0 (
      .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
      .per_frame_clken(clken), .per_img_data(data),
      .matrix_frame_vsync(v0), .matrix_frame_href(h0), .matrix_frame_clken(c0),
      .matrix_win(w0), .matrix_win_valid(wv0), .line_ovf(ovf0));

   vip_matrix_generate_nxn #(.DW(8), .KSIZE(3), .IMG_W(8), .BORDER(1)) u_dut1 (
      .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
      .per_frame_clken(clken), .per_img_data(data),
      .matrix_frame_vsync(v1), .matrix_frame_href(h1), .matrix_frame_clken(c1),
      .matrix_win(w1), .matrix_win_valid(wv1), .line_ovf(ovf1));

   vip_matrix_generate_nxn #(.DW(8), .KSIZE(5), .IMG_W(16), .BORDER(0)) u_dut5 (
      .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
      .per_frame_clken(clken), .per_img_data(data),
      .matrix_frame_vsync(v5), .matrix_frame_href(h5), .matrix_frame_clken(c5),
      .matrix_win(w5), .matrix_win_valid(wv5), .line_ovf(ovf5));

   int checks = 0;
   int errors = 0;

   logic [2:0]   d1 = '0, d2 = '0;
   int           cur_r = 0, cur_c = 0, t_r1 = 0, t_c1 = 0, t_r2 = 0, t_c2 = 0;
   logic         cap_en = 1'b0, sync_chk = 1'b0;
   logic [71:0]  cap0 [0:4][0:9];
   logic [71:0]  cap1 [0:4][0:9];
   logic [199:0] cap5 [0:4][0:9];
   logic         vld0 [0:4][0:9];
   logic         vld1 [0:4][0:9];
   logic         vld5 [0:4][0:9];
   logic [71:0]  last0;
   logic [199:0] last5;

   task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      logic [2:0] cur;
      cur = {vsync, href, clken};
      @(posedge clk);
      #1;
      d2 = d1;     d1 = cur;
      t_r2 = t_r1; t_c2 = t_c1;
      t_r1 = cur_r; t_c1 = cur_c;
      if (cap_en) begin
         if (d2[1] && d2[0]) begin
            cap0[t_r2][t_c2] = w0; vld0[t_r2][t_c2] = wv0;
            cap1[t_r2][t_c2] = w1; vld1[t_r2][t_c2] = wv1;
            cap5[t_r2][t_c2] = w5; vld5[t_r2][t_c2] = wv5;
            last0 = w0; last5 = w5;
         end else if (d2[1]) begin
            check("hold0", w0, last0);
            check("hold5", w5, last5);
         end else begin
            check("clear0", w0, '0);
         end
      end
      if (sync_chk) begin
         check("sync0", {v0, h0, c0}, d2);
         check("sync5", {v5, h5, c5}, d2);
      end
   endtask

   task automatic send_line(input int r, input int n, input bit gap);
      for (int c = 0; c < n; c++) begin
         href = 1'b1; clken = 1'b1; data = 8'(16*r + c);
         cur_r = r; cur_c = c;
         tick();
         if (gap) begin
            clken = 1'b0;
            tick();
         end
      end
      href = 1'b0; clken = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      rst = 1'b1; vsync = 1'b0; href = 1'b0; clken = 1'b0; data = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_win0", w0, '0);
      check("rst_vld0", wv0, 1'b0);
      check("rst_ovf0", ovf0, 1'b0);
      check("rst_sync0", {v0, h0, c0}, 3'b000);
      check("rst_win5", w5, '0);

      // Frame A: 8x5 ramp with clken toggling every cycle
      vsync = 1'b1; tick();
      vsync = 1'b0; tick();
      cap_en = 1'b1;
      for (int r = 0; r < 5; r++) send_line(r, 8, 1'b1);
      cap_en = 1'b0;

      check("ramp_r2c2_win", cap0[2][2], 72'h22_21_20_12_11_10_02_01_00);
      check("ramp_r2c2_vld", vld0[2][2], 1'b1);
      check("ramp_r2c1_vld", vld0[2][1], 1'b0);
      check("ramp_r0c3_win", cap0[0][3], 72'h03_02_01_00_00_00_00_00_00);
      check("ramp_r0c3_vld", vld0[0][3], 1'b0);
      check("ramp_r1c0_win", cap0[1][0], 72'h10_00_00_00_00_00_00_00_00);
      check("ramp_r3c7_win", cap0[3][7], 72'h37_36_35_27_26_25_17_16_15);
      check("ramp_r3c7_vld", vld0[3][7], 1'b1);

      check("brd_r0c0_win", cap1[0][0], 72'h00_00_00_00_00_00_00_00_00);
      check("brd_r0c1_win", cap1[0][1], 72'h01_00_00_01_00_00_01_00_00);
      check("brd_r1c1_win", cap1[1][1], 72'h11_10_10_01_00_00_01_00_00);
      check("brd_r1c1_vld", vld1[1][1], 1'b0);
      check("brd_r2c0_win", cap1[2][0], 72'h20_20_20_10_10_10_00_00_00);

      check("k5_r4c4_e00", cap5[4][4][0*8 +: 8], 8'h00);
      check("k5_r4c4_e44", cap5[4][4][24*8 +: 8], 8'h44);
      check("k5_r4c4_e23", cap5[4][4][13*8 +: 8], 8'h23);
      check("k5_r4c4_vld", vld5[4][4], 1'b1);
      check("k5_r4c7_e00", cap5[4][7][0*8 +: 8], 8'h03);
      check("k5_r4c7_e44", cap5[4][7][24*8 +: 8], 8'h47);
      check("k5_r3c4_e11", cap5[3][4][6*8 +: 8], 8'h01);
      check("k5_r3c4_e00", cap5[3][4][0*8 +: 8], 8'h00);
      check("k5_r3c4_vld", vld5[3][4], 1'b0);

      // Frame B: 10-pixel line into an 8-deep line buffer
      vsync = 1'b1; tick();
      vsync = 1'b0; tick();
      for (int c = 0; c < 10; c++) begin
         href = 1'b1; clken = 1'b1; data = 8'(c);
         tick();
         check("ovf_px", ovf0, 1'(c >= 8));
      end
      href = 1'b0; clken = 1'b0;
      tick();
      check("ovf_hold", ovf0, 1'b1);
      check("ovf_k5", ovf5, 1'b0);
      tick();
      vsync = 1'b1; tick();
      check("ovf_clr", ovf0, 1'b0);
      vsync = 1'b0; tick();

      // Frame C: reset in the middle of line 2
      vsync = 1'b1; tick();
      vsync = 1'b0; tick();
      send_line(0, 10, 1'b0);
      check("ovf_set2", ovf0, 1'b1);
      send_line(1, 8, 1'b0);
      for (int c = 0; c < 3; c++) begin
         href = 1'b1; clken = 1'b1; data = 8'(32 + c);
         tick();
      end
      rst = 1'b1;
      tick();
      check("mrst_win0", w0, '0);
      check("mrst_vld0", wv0, 1'b0);
      check("mrst_ovf0", ovf0, 1'b0);
      check("mrst_sync0", {v0, h0, c0}, 3'b000);
      check("mrst_win1", w1, '0);
      check("mrst_win5", w5, '0);
      rst = 1'b0; href = 1'b0; clken = 1'b0;
      tick();
      vsync = 1'b1; tick();
      vsync = 1'b0; href = 1'b1; clken = 1'b1; data = 8'hA5;
      tick();
      href = 1'b0; clken = 1'b0;
      tick();
      check("post_rst_win0", w0, {8'hA5, 64'h0});
      check("post_rst_win1", w1, {9{8'hA5}});
      check("post_rst_win5", w5, {8'hA5, 192'h0});
      check("post_rst_vld0", wv0, 1'b0);

      // Random control patterns against a 2-deep history of the inputs
      tick();
      tick();
      sync_chk = 1'b1;
      repeat (40) begin
         vsync = 1'($urandom_range(0, 1));
         href  = 1'($urandom_range(0, 1));
         clken = 1'($urandom_range(0, 1));
         data  = 8'($urandom);
         tick();
      end
      sync_chk = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
